// File: rtl/block_write_arbiter_if.sv
// Write-port bundle between the block input sources, the arbiter and blockArray.
// The master modport is the requester/array side; the slave modport is the arbiter.
interface block_write_arbiter_if #(
    parameter int X_BITS = 4,
    parameter int Y_BITS = 4,
    parameter int VAL_W  = 2
);
    logic                     req_a;
    logic [X_BITS-1:0]        x_a;
    logic [Y_BITS-1:0]        y_a;
    logic [VAL_W-1:0]         val_a;
    logic                     ack_a;
    logic                     req_b;
    logic [X_BITS-1:0]        x_b;
    logic [Y_BITS-1:0]        y_b;
    logic [VAL_W-1:0]         val_b;
    logic                     ack_b;
    logic                     clr_start;
    logic                     busy;
    logic                     clr_done;
    logic [X_BITS+Y_BITS-1:0] w_index;
    logic [VAL_W-1:0]         w_value;
    logic                     w_en;

    modport master (
        output req_a, x_a, y_a, val_a, req_b, x_b, y_b, val_b, clr_start,
        input  ack_a, ack_b, busy, clr_done, w_index, w_value, w_en
    );

    modport slave (
        input  req_a, x_a, y_a, val_a, req_b, x_b, y_b, val_b, clr_start,
        output ack_a, ack_b, busy, clr_done, w_index, w_value, w_en
    );
endinterface

// File: rtl/block_write_arbiter.sv
// Shares the blockArray write port between two requesters (round-robin) and
// runs a full-array clear sweep. Every output is registered.
//
// state | meaning
// IDLE  | arbitrate requests, accept clr_start
// CLEAR | write CLEAR_VAL to index cnt each cycle; cnt wrapping to 0 ends the sweep
module block_write_arbiter #(
    parameter int              X_BITS    = 4,
    parameter int              Y_BITS    = 4,
    parameter int              VAL_W     = 2,
    parameter logic [VAL_W-1:0] CLEAR_VAL = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    block_write_arbiter_if.slave  bus
);
    localparam int IDX_W = X_BITS + Y_BITS;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t           state;
    logic [IDX_W-1:0] cnt;
    logic             last_grant_b;
    logic             elig_a;
    logic             elig_b;
    logic             grant_a;
    logic             grant_b;

    // A requester whose ack is showing this cycle sits out, so a held req is a fresh write.
    always_comb begin
        elig_a  = bus.req_a && !bus.ack_a;
        elig_b  = bus.req_b && !bus.ack_b;
        grant_a = elig_a && (!elig_b || last_grant_b);
        grant_b = elig_b && !grant_a;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            last_grant_b <= 1'b1;
            bus.w_en     <= 1'b0;
            bus.w_index  <= '0;
            bus.w_value  <= '0;
            bus.ack_a    <= 1'b0;
            bus.ack_b    <= 1'b0;
            bus.busy     <= 1'b0;
            bus.clr_done <= 1'b0;
        end else begin
            bus.ack_a    <= 1'b0;
            bus.ack_b    <= 1'b0;
            bus.clr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.clr_start) begin
                        // Index 0 goes out on the accept edge so the sweep starts at T+1.
                        state       <= CLEAR;
                        bus.w_en    <= 1'b1;
                        bus.w_index <= '0;
                        bus.w_value <= CLEAR_VAL;
                        bus.busy    <= 1'b1;
                        cnt         <= IDX_W'(1);
                    end else begin
                        bus.w_en <= grant_a || grant_b;
                        if (grant_a) begin
                            bus.w_index  <= {bus.x_a, bus.y_a};
                            bus.w_value  <= bus.val_a;
                            bus.ack_a    <= 1'b1;
                            last_grant_b <= 1'b0;
                        end else if (grant_b) begin
                            bus.w_index  <= {bus.x_b, bus.y_b};
                            bus.w_value  <= bus.val_b;
                            bus.ack_b    <= 1'b1;
                            last_grant_b <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    if (cnt == '0) begin
                        state        <= IDLE;
                        bus.w_en     <= 1'b0;
                        bus.busy     <= 1'b0;
                        bus.clr_done <= 1'b1;
                    end else begin
                        bus.w_en    <= 1'b1;
                        bus.w_index <= cnt;
                        bus.w_value <= CLEAR_VAL;
                        cnt         <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_block_write_arbiter.sv
// Bench for block_write_arbiter: directed vector table, hand-written clear
// sequences, then randomized traffic against a cycle-level reference model.
module tb_block_write_arbiter;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;
    logic [1:0] mem [256];

    block_write_arbiter_if #(.X_BITS(4), .Y_BITS(4), .VAL_W(2)) bus ();

    block_write_arbiter #(.X_BITS(4), .Y_BITS(4), .VAL_W(2), .CLEAR_VAL(2'd0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for blockArray: registered outputs are stable at the falling edge.
    always @(negedge clk) if (bus.w_en === 1'b1) mem[bus.w_index] = bus.w_value;

    typedef struct {
        logic        rst;
        logic        ra;
        logic [3:0]  xa;
        logic [3:0]  ya;
        logic [1:0]  va;
        logic        rb;
        logic [3:0]  xb;
        logic [3:0]  yb;
        logic [1:0]  vb;
        logic        clr;
        logic [14:0] exp;
    } vec_t;

    vec_t vecs [11];

    function automatic logic [14:0] mk(logic en, logic [7:0] idx, logic [1:0] val,
                                       logic aa, logic ab, logic bz, logic dn);
        return {en, idx, val, aa, ab, bz, dn};
    endfunction

    function automatic logic [14:0] outs();
        return {bus.w_en, bus.w_index, bus.w_value, bus.ack_a, bus.ack_b, bus.busy, bus.clr_done};
    endfunction

    function automatic vec_t v(logic rst, logic ra, logic [3:0] xa, logic [3:0] ya, logic [1:0] va,
                               logic rb, logic [3:0] xb, logic [3:0] yb, logic [1:0] vb,
                               logic clr, logic [14:0] exp);
        vec_t r;
        r.rst = rst; r.ra = ra; r.xa = xa; r.ya = ya; r.va = va;
        r.rb = rb; r.xb = xb; r.yb = yb; r.vb = vb; r.clr = clr; r.exp = exp;
        return r;
    endfunction

    task automatic chk(string name, logic [14:0] act, logic [14:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got {en,idx,val,ackA,ackB,busy,done}=%h expected %h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference model state
    int         m_sweep;
    logic       m_last_b;
    logic       e_en, e_aa, e_ab, e_bz, e_dn;
    logic [7:0] e_idx;
    logic [1:0] e_val;

    task automatic model_step();
        logic want_a, want_b, pick_a, pick_b;
        if (reset) begin
            m_sweep = -1; m_last_b = 1'b1;
            e_en = 0; e_idx = 0; e_val = 0; e_aa = 0; e_ab = 0; e_bz = 0; e_dn = 0;
        end else if (m_sweep >= 0) begin
            e_aa = 0; e_ab = 0;
            if (m_sweep == 256) begin
                e_en = 0; e_bz = 0; e_dn = 1; m_sweep = -1;
            end else begin
                e_en = 1; e_idx = m_sweep[7:0]; e_val = 0; e_bz = 1; e_dn = 0;
                m_sweep++;
            end
        end else begin
            e_dn = 0;
            if (bus.clr_start) begin
                e_en = 1; e_idx = 0; e_val = 0; e_bz = 1; e_aa = 0; e_ab = 0;
                m_sweep = 1;
            end else begin
                want_a = bus.req_a && !e_aa;
                want_b = bus.req_b && !e_ab;
                pick_a = want_a && (!want_b || m_last_b);
                pick_b = want_b && !pick_a;
                e_en = pick_a || pick_b; e_aa = pick_a; e_ab = pick_b;
                if (pick_a) begin e_idx = {bus.x_a, bus.y_a}; e_val = bus.val_a; m_last_b = 0; end
                if (pick_b) begin e_idx = {bus.x_b, bus.y_b}; e_val = bus.val_b; m_last_b = 1; end
            end
        end
    endtask

    task automatic idle_inputs();
        bus.req_a = 0; bus.x_a = 0; bus.y_a = 0; bus.val_a = 0;
        bus.req_b = 0; bus.x_b = 0; bus.y_b = 0; bus.val_b = 0;
        bus.clr_start = 0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        for (int i = 0; i < 256; i++) mem[i] = 2'd3;
        reset = 1;
        idle_inputs();

        // Directed table: reset with everything asserted, single write, fresh contention.
        vecs[0]  = v(1, 1, 4'h3, 4'h9, 2, 1, 4'h4, 4'h5, 3, 1, mk(0, 8'h00, 0, 0, 0, 0, 0));
        vecs[1]  = v(1, 1, 4'h3, 4'h9, 2, 1, 4'h4, 4'h5, 3, 1, mk(0, 8'h00, 0, 0, 0, 0, 0));
        vecs[2]  = v(1, 1, 4'h3, 4'h9, 2, 1, 4'h4, 4'h5, 3, 1, mk(0, 8'h00, 0, 0, 0, 0, 0));
        vecs[3]  = v(0, 1, 4'h3, 4'h9, 2, 0, 4'h0, 4'h0, 0, 0, mk(1, 8'h39, 2, 1, 0, 0, 0));
        vecs[4]  = v(0, 0, 4'h3, 4'h9, 2, 0, 4'h0, 4'h0, 0, 0, mk(0, 8'h39, 2, 0, 0, 0, 0));
        vecs[5]  = v(1, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0, mk(0, 8'h00, 0, 0, 0, 0, 0));
        vecs[6]  = v(0, 1, 4'h1, 4'h2, 1, 1, 4'h4, 4'h5, 3, 0, mk(1, 8'h12, 1, 1, 0, 0, 0));
        vecs[7]  = v(0, 1, 4'h1, 4'h2, 1, 1, 4'h4, 4'h5, 3, 0, mk(1, 8'h45, 3, 0, 1, 0, 0));
        vecs[8]  = v(0, 1, 4'h1, 4'h2, 1, 1, 4'h4, 4'h5, 3, 0, mk(1, 8'h12, 1, 1, 0, 0, 0));
        vecs[9]  = v(0, 1, 4'h1, 4'h2, 1, 1, 4'h4, 4'h5, 3, 0, mk(1, 8'h45, 3, 0, 1, 0, 0));
        vecs[10] = v(0, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0, mk(0, 8'h45, 3, 0, 0, 0, 0));

        @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            reset = vecs[i].rst;
            bus.req_a = vecs[i].ra; bus.x_a = vecs[i].xa; bus.y_a = vecs[i].ya; bus.val_a = vecs[i].va;
            bus.req_b = vecs[i].rb; bus.x_b = vecs[i].xb; bus.y_b = vecs[i].yb; bus.val_b = vecs[i].vb;
            bus.clr_start = vecs[i].clr;
            tick();
            chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // Clear sweep with a late request from B and an ignored clr_start mid-sweep.
        idle_inputs();
        bus.clr_start = 1;
        for (int k = 1; k <= 259; k++) begin
            tick();
            if (k <= 256)      chk("sweep", outs(), mk(1, 8'(k - 1), 0, 0, 0, 1, 0));
            else if (k == 257) chk("sweep_done", outs(), mk(0, 8'hFF, 0, 0, 0, 0, 1));
            else if (k == 258) chk("b_after_clear", outs(), mk(1, 8'hFF, 1, 0, 1, 0, 0));
            else               chk("b_dropped", outs(), mk(0, 8'hFF, 1, 0, 0, 0, 0));
            if (k == 257) begin
                int nz;
                nz = 0;
                for (int i = 0; i < 256; i++) if (mem[i] !== 2'd0) nz++;
                n_chk++;
                if (nz != 0) begin
                    n_err++;
                    $display("FAIL readback: %0d entries nonzero, expected 0", nz);
                end
            end
            if (k == 1)   bus.clr_start = 0;
            if (k == 9)   begin bus.req_b = 1; bus.x_b = 4'hF; bus.y_b = 4'hF; bus.val_b = 1; end
            if (k == 49)  bus.clr_start = 1;
            if (k == 50)  bus.clr_start = 0;
            if (k == 258) bus.req_b = 0;
        end

        // clr_start during the clr_done cycle chains straight into a new sweep.
        bus.clr_start = 1;
        for (int k = 1; k <= 257; k++) begin
            tick();
            if (k == 1) bus.clr_start = 0;
            if (k == 256) bus.clr_start = 1;
        end
        chk("chain_done", outs(), mk(0, 8'hFF, 0, 0, 0, 0, 1));
        for (int k = 1; k <= 101; k++) begin
            tick();
            if (k == 1) bus.clr_start = 0;
            if (k == 1 || k == 101) chk("chain_sweep", outs(), mk(1, 8'(k - 1), 0, 0, 0, 1, 0));
        end

        // Reset mid-sweep at index 100, then a fresh clear restarts from 0.
        reset = 1;
        tick();
        chk("abort", outs(), mk(0, 8'h00, 0, 0, 0, 0, 0));
        reset = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("abort_quiet", outs(), mk(0, 8'h00, 0, 0, 0, 0, 0));
        end
        bus.clr_start = 1;
        tick();
        chk("restart", outs(), mk(1, 8'h00, 0, 0, 0, 1, 0));
        bus.clr_start = 0;
        tick();
        chk("restart_next", outs(), mk(1, 8'h01, 0, 0, 0, 1, 0));

        // Randomized traffic against the reference model.
        reset = 1;
        idle_inputs();
        for (int c = 0; c < 4000; c++) begin
            model_step();
            tick();
            chk("random", outs(), mk(e_en, e_idx, e_val, e_aa, e_ab, e_bz, e_dn));
            reset = ($urandom_range(0, 499) == 0) || (c < 2);
            bus.clr_start = ($urandom_range(0, 399) == 0);
            if (bus.ack_a) begin
                bus.req_a = 1'($urandom_range(0, 1));
                bus.x_a = 4'($urandom); bus.y_a = 4'($urandom); bus.val_a = 2'($urandom);
            end else if (!bus.req_a && $urandom_range(0, 2) == 0) begin
                bus.req_a = 1;
                bus.x_a = 4'($urandom); bus.y_a = 4'($urandom); bus.val_a = 2'($urandom);
            end
            if (bus.ack_b) begin
                bus.req_b = 1'($urandom_range(0, 1));
                bus.x_b = 4'($urandom); bus.y_b = 4'($urandom); bus.val_b = 2'($urandom);
            end else if (!bus.req_b && $urandom_range(0, 2) == 0) begin
                bus.req_b = 1;
                bus.x_b = 4'($urandom); bus.y_b = 4'($urandom); bus.val_b = 2'($urandom);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
